dma_priority_resolver: RTL and testbench
========================================

DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of DMA channels; only value 4 is supported.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port commandReg, input, 8, command register.
- bit2: controller disable.
- bit4: rotating priority.
- bit6: DREQ active-low.
- bit7: DACK active-high.
REQ-005 SHALL have port requestReg, input, 8, software request register; bits[3:0] are per-channel software requests.
REQ-006 SHALL have port maskReg, input, 8, mask register; bits[3:0] are per-channel masks.
REQ-007 SHALL have port DREQ, input, 4, hardware channel requests.
REQ-008 SHALL have port HLDA, input, 1, hold acknowledge from the CPU.
REQ-009 SHALL have port svc_end, input, 1, one-cycle pulse from timing control marking the end of service.
REQ-010 SHALL have port HRQ, output, 1, hold request to the CPU.
REQ-011 SHALL have port DACK, output, 4, channel acknowledge, with polarity set by commandReg[7].
REQ-012 SHALL have port grant_vld, output, 1, high while a channel is being serviced.
REQ-013 SHALL have port grant_ch, output, 2, index of the serviced channel.

Function
REQ-014 SHALL compute the effective request per channel as eff[i] = ((DREQ[i] XOR commandReg[6]) AND NOT maskReg[i]) OR requestReg[i]; software requests are not maskable.
REQ-015 SHALL implement the FSM IDLE -> WAIT_HLDA -> ACTIVE -> RELEASE -> IDLE.
REQ-016 IDLE: when commandReg[2]=0 and any eff=1, SHALL go to WAIT_HLDA, with HRQ=1 from the next cycle.
REQ-017 WAIT_HLDA: HRQ SHALL stay 1 and the winner SHALL be re-resolved every cycle.
REQ-018 WAIT_HLDA: on HLDA=1, SHALL latch the winner into grant_ch and go to ACTIVE.
REQ-019 WAIT_HLDA: if all eff=0, or commandReg[2]=1, while HLDA=0, SHALL return to IDLE with HRQ=0 the next cycle.
REQ-020 ACTIVE: grant_vld SHALL be 1 and DACK[grant_ch] SHALL be active, starting the cycle after HLDA is sampled high.
REQ-021 ACTIVE: grant_ch SHALL be frozen, ignoring new or higher-priority requests.
REQ-022 ACTIVE: on svc_end=1, SHALL go to RELEASE.
REQ-023 ACTIVE: on HLDA=0 (abort), SHALL go to RELEASE without a rotation update.
REQ-024 A commandReg[2] change during ACTIVE SHALL be ignored.
REQ-025 RELEASE SHALL last exactly one cycle with HRQ=0, grant_vld=0 and all DACK inactive.
REQ-026 RELEASE SHALL then return to IDLE.
REQ-027 Fixed priority (commandReg[4]=0): channel 0 highest, channel 3 lowest.
REQ-028 Rotating priority (commandReg[4]=1): after a service ended by svc_end, the served channel SHALL become lowest priority and channel (served+1) mod 4 highest.
REQ-029 The rotation pointer SHALL be forced to 0 (channel 0 highest) whenever commandReg[4]=0.
REQ-030 DACK[i] SHALL equal ack[i] when commandReg[7]=1 and NOT ack[i] when commandReg[7]=0, where ack is registered one-hot or zero.
REQ-031 Simultaneous svc_end and HLDA fall SHALL be treated as a normal end, with rotation updated.
REQ-032 The minimum gap between consecutive grants SHALL be RELEASE + IDLE + WAIT_HLDA = 3 cycles.

Reset
REQ-033 RESET=0 SHALL asynchronously force the state to IDLE, HRQ=0, ack=0, grant_vld=0, grant_ch=0 and rotation pointer=0.
REQ-034 During reset, DACK SHALL follow REQ-030 with ack=0, giving all inactive.
REQ-035 Reset asserted mid-ACTIVE SHALL drop HRQ and DACK immediately.
REQ-036 Reset release SHALL take effect on the next CLK edge.

Configuration
REQ-037 With DMA_PR_REQ_SYNC_EN defined, DREQ SHALL pass through a two-flop synchronizer before REQ-014, adding 2 cycles of request latency.
REQ-038 Without DMA_PR_REQ_SYNC_EN, DREQ SHALL be used directly, and HRQ SHALL rise 1 cycle after eff rises.

Verification
REQ-039 Fixed mode: cmd=0x00, mask=0x00, DREQ=4'b0000 then 4'b1010, HLDA raised 2 cycles after HRQ -> grant_ch=1, DACK=4'b1101; after svc_end, HRQ=0 for 1 cycle.
REQ-040 Rotating mode: cmd=0x10, DREQ=4'b1111 held, 4 services -> grant_ch sequence 0,1,2,3, then 0.
REQ-041 Mask and software request: mask=0x0F, DREQ=4'b1111, requestReg=0x04 -> grant_ch=2; with requestReg=0x00, HRQ stays 0.
REQ-042 Polarity: cmd=0xC0, DREQ=4'b1110 -> channel 0 granted and DACK=4'b0001.
REQ-043 Abort: HLDA dropped in ACTIVE with cmd=0x10 on channel 1 -> RELEASE, and the next grant from DREQ=4'b1111 is channel 0 (no rotation).
REQ-044 Reset: RESET=0 asserted in ACTIVE -> HRQ=0 and DACK=4'b1111 within the same cycle, with no CLK edge required.

Source files
------------

// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver: picks one DMA channel, negotiates the bus with the CPU
// through HRQ/HLDA, then acknowledges the winner until the service ends.
// Four channels only. Fixed or rotating priority.
// Optional build macro: DMA_PR_REQ_SYNC_EN puts DREQ through a two-flop
// synchronizer before it is used, which adds 2 cycles of request latency.
module dma_priority_resolver #(
    parameter int CH_NUM = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic [CH_NUM-1:0] DREQ,
    input  logic              HLDA,
    input  logic              svc_end,
    output logic              HRQ,
    output logic [CH_NUM-1:0] DACK,
    output logic              grant_vld,
    output logic [1:0]        grant_ch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_HLDA,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    state_t     r_state, w_next;
    logic [3:0] w_dreq, w_eff, w_rreq, w_ack_next;
    logic [7:0] w_dbl;
    logic [1:0] w_off, w_win, w_gnt_next;
    logic       w_any;
    logic [1:0] r_rot, r_grant_ch;
    logic [3:0] r_ack;
    logic       r_hrq, r_grant_vld;

    // Command, request and mask bits that this block does not look at.
    logic w_unused;
    assign w_unused = ^{commandReg[5], commandReg[3], commandReg[1:0],
                        requestReg[7:4], maskReg[7:4]};

`ifdef DMA_PR_REQ_SYNC_EN
    logic [3:0] r_dreq_meta, r_dreq_sync;

    // Two-flop synchronizer for the asynchronous hardware requests.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_dreq_meta <= '0;
            r_dreq_sync <= '0;
        end else begin
            r_dreq_meta <= DREQ;
            r_dreq_sync <= r_dreq_meta;
        end
    end
    assign w_dreq = r_dreq_sync;
`else
    assign w_dreq = DREQ;
`endif

    // DREQ polarity is set by commandReg[6]. Software requests bypass the mask.
    assign w_eff = ((w_dreq ^ {4{commandReg[6]}}) & ~maskReg[3:0]) | requestReg[3:0];
    assign w_any = |w_eff;

    // Rotate the requests so the highest-priority channel lands in bit 0.
    assign w_dbl  = {w_eff, w_eff} >> r_rot;
    assign w_rreq = w_dbl[3:0];

    // Lowest set bit of the rotated vector, then map it back to a channel.
    always_comb begin
        w_off = 2'd0;
        casez (w_rreq)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
        w_win = r_rot + w_off;
    end

    // Next-state logic for the bus handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!commandReg[2] && w_any) w_next = S_WAIT_HLDA;
            end
            S_WAIT_HLDA: begin
                if (HLDA)                          w_next = w_any ? S_ACTIVE : S_IDLE;
                else if (!w_any || commandReg[2])  w_next = S_IDLE;
            end
            S_ACTIVE: begin
                // Both svc_end and HLDA low end the service. Only svc_end rotates.
                if (svc_end || !HLDA) w_next = S_RELEASE;
            end
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // The winner is latched when ACTIVE is entered and is held after that.
    assign w_gnt_next = (r_state == S_WAIT_HLDA) ? w_win : r_grant_ch;
    assign w_ack_next = (w_next == S_ACTIVE) ? (4'b0001 << w_gnt_next) : 4'b0000;

    // State register plus registered outputs, all decoded from the next state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_hrq       <= 1'b0;
            r_grant_vld <= 1'b0;
            r_grant_ch  <= 2'd0;
            r_ack       <= 4'b0000;
        end else begin
            r_state     <= w_next;
            r_hrq       <= (w_next == S_WAIT_HLDA) || (w_next == S_ACTIVE);
            r_grant_vld <= (w_next == S_ACTIVE);
            r_ack       <= w_ack_next;
            if (r_state == S_WAIT_HLDA && w_next == S_ACTIVE) r_grant_ch <= w_win;
        end
    end

    // Rotation pointer. In fixed mode it is held at 0. In rotating mode it
    // moves past the served channel only when the service ends normally.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                                r_rot <= 2'd0;
        else if (!commandReg[4])                   r_rot <= 2'd0;
        else if (r_state == S_ACTIVE && svc_end)   r_rot <= r_grant_ch + 2'd1;
    end

    assign HRQ       = r_hrq;
    assign grant_vld = r_grant_vld;
    assign grant_ch  = r_grant_ch;
    // DACK polarity is set by commandReg[7]. While r_ack is zero, every DACK is inactive.
    assign DACK      = commandReg[7] ? r_ack : ~r_ack;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Scoreboard bench for dma_priority_resolver. A CPU-side task pushes the
// expected {grant_ch, DACK} for each grant. A monitor pops one entry on every
// rising edge of grant_vld and compares it against the outputs.
module tb_dma_priority_resolver;

    logic       CLK, RESET;
    logic [7:0] commandReg, requestReg, maskReg;
    logic [3:0] DREQ;
    logic       HLDA, svc_end;
    logic       HRQ, grant_vld;
    logic [3:0] DACK;
    logic [1:0] grant_ch;

    int n_pass = 0;
    int n_tot  = 0;
    logic [5:0] sb_q[$];
    logic       prev_vld = 1'b0;

    dma_priority_resolver #(.CH_NUM(4)) dut (
        .CLK(CLK), .RESET(RESET), .commandReg(commandReg), .requestReg(requestReg),
        .maskReg(maskReg), .DREQ(DREQ), .HLDA(HLDA), .svc_end(svc_end),
        .HRQ(HRQ), .DACK(DACK), .grant_vld(grant_vld), .grant_ch(grant_ch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [3:0] idle_dack();
        return commandReg[7] ? 4'b0000 : 4'b1111;
    endfunction

    // Monitor: one scoreboard entry is consumed on each grant.
    always @(negedge CLK) begin
        if (grant_vld && !prev_vld) begin
            if (sb_q.size() == 0) chk("sb_unexpected_grant", 8'(grant_ch), 8'hFF);
            else begin
                logic [5:0] e;
                e = sb_q.pop_front();
                chk("sb_grant_ch", 8'(grant_ch), 8'(e[5:4]));
                chk("sb_dack",     8'(DACK),     8'(e[3:0]));
            end
        end
        prev_vld <= grant_vld;
    end

    // CPU side of one service. mode 0: svc_end, 1: HLDA abort, 2: both together.
    task automatic service(input logic [1:0] ch, input logic [3:0] dk, input int mode);
        int n = 0;
        while (!HRQ && n < 20) begin @(negedge CLK); n++; end
        chk("hrq_rise", 8'(HRQ), 8'd1);
        sb_q.push_back({ch, dk});
        repeat (2) @(posedge CLK);
        #1 HLDA = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("active_vld", 8'(grant_vld), 8'd1);
        repeat (2) @(posedge CLK);
        chk("grant_hold", 8'(grant_ch), 8'(ch));
        #1;
        if (mode != 0) HLDA = 1'b0;
        if (mode != 1) svc_end = 1'b1;
        @(posedge CLK); #1;
        svc_end = 1'b0;
        HLDA    = 1'b0;
        @(negedge CLK);
        chk("rel_hrq",  8'(HRQ),       8'd0);
        chk("rel_vld",  8'(grant_vld), 8'd0);
        chk("rel_dack", 8'(DACK),      8'(idle_dack()));
        @(posedge CLK); #1;
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk(nm, 8'(HRQ), 8'd0);
        end
    endtask

    initial begin
        RESET = 1'b0; commandReg = 8'h00; requestReg = 8'h00; maskReg = 8'h00;
        DREQ = 4'b0000; HLDA = 1'b0; svc_end = 1'b0;
        #12;
        chk("rst_hrq",   8'(HRQ),       8'd0);
        chk("rst_dack",  8'(DACK),      8'hF);
        chk("rst_vld",   8'(grant_vld), 8'd0);
        chk("rst_ch",    8'(grant_ch),  8'd0);
        @(posedge CLK); #1 RESET = 1'b1;

        // Fixed priority: no requests, then 1010 grants channel 1.
        idle_cycles(3, "idle_no_req");
        DREQ = 4'b1010;
        service(2'd1, 4'b1101, 0);
        DREQ = 4'b0000;
        idle_cycles(4, "idle_after_fixed");

        // Controller disabled: a request must not raise HRQ.
        commandReg = 8'h04; DREQ = 4'b1111;
        idle_cycles(4, "disabled");
        DREQ = 4'b0000; commandReg = 8'h00;
        @(posedge CLK); #1;

        // Masked hardware requests. A software request still wins.
        maskReg = 8'h0F; DREQ = 4'b1111; requestReg = 8'h04;
        service(2'd2, 4'b1011, 0);
        requestReg = 8'h00;
        idle_cycles(5, "masked_idle");
        maskReg = 8'h00; DREQ = 4'b0000;
        @(posedge CLK); #1;

        // Active-low DREQ and active-high DACK.
        commandReg = 8'hC0; DREQ = 4'b1110;
        service(2'd0, 4'b0001, 0);
        DREQ = 4'b1111;
        idle_cycles(3, "polarity_idle");
        commandReg = 8'h00; DREQ = 4'b0000;
        @(posedge CLK); #1;

        // Rotating mode: an aborted service on channel 1 leaves the pointer alone.
        commandReg = 8'h10; DREQ = 4'b0010;
        service(2'd1, 4'b1101, 1);
        DREQ = 4'b1111;
        service(2'd0, 4'b1110, 0);
        DREQ = 4'b0000; commandReg = 8'h00;
        idle_cycles(2, "rot_clear");

        // Rotating sequence 0,1,2,3,0. The first service ends with svc_end and HLDA falling together.
        commandReg = 8'h10; DREQ = 4'b1111;
        service(2'd0, 4'b1110, 2);
        service(2'd1, 4'b1101, 0);
        service(2'd2, 4'b1011, 0);
        service(2'd3, 4'b0111, 0);
        service(2'd0, 4'b1110, 0);
        DREQ = 4'b0000; commandReg = 8'h00;
        idle_cycles(2, "rot_done");

        // Asynchronous reset in ACTIVE.
        DREQ = 4'b0001;
        begin
            int n = 0;
            while (!HRQ && n < 20) begin @(negedge CLK); n++; end
        end
        sb_q.push_back({2'd0, 4'b1110});
        @(posedge CLK); #1 HLDA = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("pre_rst_vld", 8'(grant_vld), 8'd1);
        #2 RESET = 1'b0;
        #1;
        chk("async_rst_hrq",  8'(HRQ),       8'd0);
        chk("async_rst_dack", 8'(DACK),      8'hF);
        chk("async_rst_vld",  8'(grant_vld), 8'd0);
        HLDA = 1'b0; DREQ = 4'b0000;
        @(posedge CLK); #1 RESET = 1'b1;
        @(negedge CLK);
        chk("sb_empty", 8'(sb_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
